// File: rtl/seq_multiplier_if.sv
// Handshake and result bundle between the ALU control FSM and the shift-add multiplier.
interface seq_multiplier_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] prod_hi;
  logic [WIDTH-1:0] prod_lo;

  modport master (
    output start, is_signed, a, b,
    input  busy, done, prod_hi, prod_lo
  );

  modport slave (
    input  start, is_signed, a, b,
    output busy, done, prod_hi, prod_lo
  );
endinterface

// File: rtl/seq_multiplier.sv
// Multi-cycle shift-add multiplier: sign-magnitude operands, one multiplier bit per clock,
// sign applied to the full 2*WIDTH-bit accumulator on the way out.
module seq_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic            clk,
  input  logic            rst,
  seq_multiplier_if.slave bus
);

  localparam int PW = 2 * WIDTH;
  localparam int IW = $clog2(WIDTH);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic             neg;
  logic [PW-1:0]    acc;
  logic [CW-1:0]    cnt;
  logic             busy_r;
  logic             done_r;
  logic [PW-1:0]    prod_r;

  // -2^(WIDTH-1) negates to itself, which read as unsigned is the correct magnitude.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
    if (sgn && v[WIDTH-1])
      return ~v + WIDTH'(1);
    return v;
  endfunction

  function automatic logic [PW-1:0] apply_sign(input logic [PW-1:0] v, input logic n);
    if (n)
      return ~v + PW'(1);
    return v;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      mag_a  <= '0;
      mag_b  <= '0;
      neg    <= 1'b0;
      acc    <= '0;
      cnt    <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      prod_r <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            mag_a  <= magnitude(bus.a, bus.is_signed);
            mag_b  <= magnitude(bus.b, bus.is_signed);
            neg    <= bus.is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            acc    <= '0;
            cnt    <= '0;
            busy_r <= 1'b1;
            state  <= RUN;
          end else begin
            busy_r <= 1'b0;
            state  <= IDLE;
          end
        end
        RUN: begin
          // cnt sweeps 0..WIDTH-1 adding partial products; the extra pass at WIDTH publishes.
          if (cnt == CW'(WIDTH)) begin
            prod_r <= apply_sign(acc, neg);
            busy_r <= 1'b0;
            done_r <= 1'b1;
            state  <= DONE;
          end else begin
            if (mag_b[cnt[IW-1:0]])
              acc <= acc + ({{WIDTH{1'b0}}, mag_a} << cnt);
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          busy_r <= 1'b0;
          done_r <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.prod_hi = prod_r[PW-1:WIDTH];
  assign bus.prod_lo = prod_r[WIDTH-1:0];

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier: latency, signed/unsigned products, ignored start, reset abort.
module tb_seq_multiplier;

  localparam int WIDTH = 32;
  localparam int LAT   = WIDTH + 1;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  seq_multiplier_if #(.WIDTH(WIDTH)) bus ();

  seq_multiplier #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [31:0] av, input logic [31:0] bv, input logic sgn);
    bus.a         = av;
    bus.b         = bv;
    bus.is_signed = sgn;
    bus.start     = 1'b1;
  endtask

  // Consumes the accept edge, then waits (bounded) for done; optionally pokes start mid-run.
  task automatic wait_result(input string tag, input logic [63:0] exp, input bit poke);
    int lat;
    int busy_cnt;
    bit seen;
    lat      = 0;
    busy_cnt = 0;
    seen     = 1'b0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk({tag, "_busy_at_accept"}, {63'd0, bus.busy}, 64'd1);
    chk({tag, "_done_at_accept"}, {63'd0, bus.done}, 64'd0);
    for (int i = 1; i <= LAT + 6; i++) begin
      if (poke && i == 5) begin
        bus.start = 1'b1;
        bus.a     = 32'd100;
        bus.b     = 32'd100;
      end
      if (poke && i == 9) bus.start = 1'b0;
      @(posedge clk);
      #1;
      lat = i;
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      if (bus.busy) busy_cnt++;
    end
    chk({tag, "_done_seen"}, {63'd0, seen}, 64'd1);
    chk({tag, "_latency"}, 64'(lat), 64'(LAT));
    chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(WIDTH));
    chk({tag, "_busy_in_done"}, {63'd0, bus.busy}, 64'd0);
    chk({tag, "_prod"}, {bus.prod_hi, bus.prod_lo}, exp);
  endtask

  initial begin
    total         = 0;
    bad           = 0;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.is_signed = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", {63'd0, bus.busy}, 64'd0);
    chk("reset_done", {63'd0, bus.done}, 64'd0);
    chk("reset_prod", {bus.prod_hi, bus.prod_lo}, 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    issue(32'd3, 32'd5, 1'b0);
    wait_result("u_3x5", 64'd15, 1'b0);
    @(posedge clk);
    #1;
    chk("idle_done_drop", {63'd0, bus.done}, 64'd0);
    chk("hold_after_done", {bus.prod_hi, bus.prod_lo}, 64'd15);

    issue(32'hFFFF_FFF9, 32'd6, 1'b1);
    wait_result("s_m7x6", 64'hFFFF_FFFF_FFFF_FFD6, 1'b0);

    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    wait_result("u_max_sq", 64'hFFFF_FFFE_0000_0001, 1'b0);

    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    wait_result("s_m1_sq", 64'h0000_0000_0000_0001, 1'b0);

    issue(32'h8000_0000, 32'h8000_0000, 1'b1);
    wait_result("s_min_sq", 64'h4000_0000_0000_0000, 1'b0);

    issue(32'h8000_0000, 32'd2, 1'b0);
    wait_result("u_msb_x2", 64'h0000_0001_0000_0000, 1'b0);

    issue(32'd5, 32'hFFFF_FFFD, 1'b1);
    wait_result("s_5xm3", 64'hFFFF_FFFF_FFFF_FFF1, 1'b0);

    issue(32'd0, 32'hFFFF_FFFB, 1'b1);
    wait_result("s_zero", 64'd0, 1'b0);

    // Mid-run start with different operands must not disturb the running product.
    issue(32'd3, 32'd5, 1'b0);
    wait_result("ignore_start", 64'd15, 1'b1);

    // Back-to-back: start presented while done is high.
    issue(32'd7, 32'd9, 1'b0);
    wait_result("b2b_first", 64'd63, 1'b0);
    issue(32'd11, 32'd13, 1'b0);
    wait_result("b2b_second", 64'd143, 1'b0);
    @(posedge clk);
    #1;

    // Reset at RUN cycle 10, checked before the next clock edge.
    issue(32'd3, 32'd5, 1'b0);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("pre_rst_busy", {63'd0, bus.busy}, 64'd1);
    rst = 1'b1;
    #1;
    chk("rst_async_busy", {63'd0, bus.busy}, 64'd0);
    chk("rst_async_done", {63'd0, bus.done}, 64'd0);
    chk("rst_async_prod", {bus.prod_hi, bus.prod_lo}, 64'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_idle", {63'd0, bus.busy}, 64'd0);
    issue(32'd2, 32'd3, 1'b0);
    wait_result("after_rst_2x3", 64'd6, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
